// File: rtl/adder_slice_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_slice_scheduler_if
// Brief    : Request/response bundle for the shared adder slice scheduler.
//            Two operand requesters plus one result channel; master is the
//            requester/consumer side, slave is the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_slice_scheduler_if #(
  parameter int WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;

  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );
endinterface
`default_nettype wire

// File: rtl/adder_slice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adder_slice_scheduler
// Brief    : Shares one SLICE-bit adder between two round-robin requesters,
//            producing a WIDTH-bit sum + carry-out over WIDTH/SLICE beats,
//            least significant slice first.
// Revision : 1.0 - initial release
// ============================================================================
module adder_slice_scheduler #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  adder_slice_scheduler_if.slave    bus
);

  localparam int BEATS  = WIDTH / SLICE;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              id_q, id_d;
  logic              last_grant_q, last_grant_d;
  logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_id_q, rsp_id_d;

  logic              grant1;
  logic              accept;
  logic [SLICE:0]    slice_sum;
  logic [WIDTH-1:0]  acc_next;

  // Round-robin pick; a lone valid wins regardless of the pointer
  always_comb begin
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant1 = ~last_grant_q;
    end else begin
      grant1 = bus.req1_valid;
    end
    accept = (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid) && !rst;
  end

  assign bus.req0_ready = accept && !grant1;
  assign bus.req1_ready = accept && grant1;

  // Operands shift down one slice per beat, so the slice always sits in the low bits
  assign slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]}
                   + {{SLICE{1'b0}}, carry_q};

  // Each new slice enters at the top; after BEATS beats the sum is in order
  generate
    if (BEATS > 1) begin : g_acc_shift
      assign acc_next = {slice_sum[SLICE-1:0], acc_q[WIDTH-1:SLICE]};
    end else begin : g_acc_single
      assign acc_next = slice_sum[SLICE-1:0];
    end
  endgenerate

  // Sequencer next-state: capture on accept, one slice per ADD edge, hold in DONE
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    beat_d       = beat_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d          = grant1 ? bus.req1_a   : bus.req0_a;
          b_d          = grant1 ? bus.req1_b   : bus.req0_b;
          carry_d      = grant1 ? bus.req1_cin : bus.req0_cin;
          acc_d        = '0;
          beat_d       = '0;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = S_ADD;
        end
      end
      S_ADD: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        acc_d   = acc_next;
        carry_d = slice_sum[SLICE];
        beat_d  = beat_q + BEAT_W'(1);
        if (beat_q == LAST_BEAT) begin
          rsp_sum_d  = acc_next;
          rsp_cout_d = slice_sum[SLICE];
          rsp_id_d   = id_q;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      beat_q       <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      carry_q      <= carry_d;
      beat_q       <= beat_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state_q == S_ADD) || (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_adder_slice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_slice_scheduler
// Brief    : Directed self-checking bench for adder_slice_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_slice_scheduler;

  localparam int WIDTH = 64;
  localparam int SLICE = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  adder_slice_scheduler_if #(.WIDTH(WIDTH)) bus ();

  adder_slice_scheduler #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until rsp_valid is high; returns number of edges waited
  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (!bus.rsp_valid && cycles < 30) begin
      step();
      cycles++;
    end
    if (!bus.rsp_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  // Wait (bounded) for a grant; returns granted id
  task automatic wait_grant(input string tag, output int gid);
    int n;
    n = 0;
    gid = 0;
    while (!(bus.req0_ready || bus.req1_ready) && n < 30) begin
      step();
      n++;
    end
    if (!(bus.req0_ready || bus.req1_ready)) check({tag, "_timeout"}, 0, 1);
    gid = bus.req1_ready ? 1 : 0;
  endtask

  logic [WIDTH-1:0] v0_a [4];
  logic [WIDTH-1:0] v0_b [4];
  logic             v0_c [4];
  logic [WIDTH-1:0] v1_a [4];
  logic [WIDTH-1:0] v1_b [4];
  logic             v1_c [4];

  initial begin
    int cyc;
    int gid;
    int i0;
    int i1;
    logic [WIDTH:0] model;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic ec;
    bit saw_valid;

    n_checks = 0;
    n_pass   = 0;

    v0_a[0] = 64'h0000_0000_0000_0001; v0_b[0] = 64'h0000_0000_0000_0002; v0_c[0] = 1'b0;
    v0_a[1] = 64'h8000_0000_0000_0000; v0_b[1] = 64'h8000_0000_0000_0000; v0_c[1] = 1'b1;
    v0_a[2] = 64'h0000_FFFF_0000_FFFF; v0_b[2] = 64'h0000_0001_0000_0001; v0_c[2] = 1'b0;
    v0_a[3] = 64'hDEAD_BEEF_CAFE_F00D; v0_b[3] = 64'h2152_4110_3501_0FF2; v0_c[3] = 1'b1;
    v1_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; v1_b[0] = 64'hFFFF_FFFF_FFFF_FFFF; v1_c[0] = 1'b1;
    v1_a[1] = 64'h1111_2222_3333_4444; v1_b[1] = 64'h5555_6666_7777_8888; v1_c[1] = 1'b0;
    v1_a[2] = 64'hFFFF_0000_FFFF_0000; v1_b[2] = 64'h0001_0000_0001_0000; v1_c[2] = 1'b1;
    v1_a[3] = 64'h0000_0000_0000_0000; v1_b[3] = 64'h0000_0000_0000_0000; v1_c[3] = 1'b0;

    // Reset with both requesters asking
    rst = 1'b1;
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.req0_b     = 64'h0;
    bus.req0_cin   = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 64'h0000_0000_0000_FFFF;
    bus.req1_b     = 64'h1;
    bus.req1_cin   = 1'b0;
    step();
    step();
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_sum", bus.rsp_sum, 0);
    check("rst_rsp_cout", bus.rsp_cout, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_busy", bus.busy, 0);

    // Release: first contention goes to req0 (full carry ripple vector)
    rst = 1'b0;
    #1;
    check("first_grant_r0", bus.req0_ready, 1);
    check("first_grant_r1", bus.req1_ready, 0);
    step();                       // accept edge E0
    bus.req0_valid = 1'b0;
    check("ripple_busy", bus.busy, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("ripple_valid_e%0d", i), bus.rsp_valid, (i == 4) ? 1 : 0);
    end
    check("ripple_sum", bus.rsp_sum, 0);
    check("ripple_cout", bus.rsp_cout, 1);
    check("ripple_id", bus.rsp_id, 0);

    // Back-pressure: DONE held, outputs stable, req1 waiting
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum},
            {1'b1, 1'b0, 1'b1, 64'h0});
      check("bp_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);
    end
    bus.rsp_ready = 1'b1;
    step();                       // pop edge
    bus.rsp_ready = 1'b0;
    check("pop_valid", bus.rsp_valid, 0);
    check("pop_sum_held", bus.rsp_sum, 0);
    check("pop_r1_ready", bus.req1_ready, 1);
    step();                       // accept of slice-boundary vector
    bus.req1_valid = 1'b0;
    wait_valid("bound", cyc);
    check("bound_latency", cyc, 4);
    check("bound_sum", bus.rsp_sum, 64'h0000_0000_0001_0000);
    check("bound_cout", bus.rsp_cout, 0);
    check("bound_id", bus.rsp_id, 1);
    bus.rsp_ready = 1'b1;
    step();

    // Fairness: both valid, consumer always ready; last grant was req1
    i0 = 0;
    i1 = 0;
    bus.req0_a = v0_a[0]; bus.req0_b = v0_b[0]; bus.req0_cin = v0_c[0];
    bus.req1_a = v1_a[0]; bus.req1_b = v1_b[0]; bus.req1_cin = v1_c[0];
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    for (int t = 0; t < 8; t++) begin
      wait_grant("fair", gid);
      check("fair_one_hot", {bus.req0_ready, bus.req1_ready}, (t % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("fair_gid_t%0d", t), gid, t % 2);
      if (gid == 0) begin
        ea = v0_a[i0]; eb = v0_b[i0]; ec = v0_c[i0];
      end else begin
        ea = v1_a[i1]; eb = v1_b[i1]; ec = v1_c[i1];
      end
      model = {1'b0, ea} + {1'b0, eb} + {{WIDTH{1'b0}}, ec};
      step();                     // accept edge
      if (gid == 0) begin
        i0++;
        if (i0 < 4) begin bus.req0_a = v0_a[i0]; bus.req0_b = v0_b[i0]; bus.req0_cin = v0_c[i0]; end
        else bus.req0_valid = 1'b0;
      end else begin
        i1++;
        if (i1 < 4) begin bus.req1_a = v1_a[i1]; bus.req1_b = v1_b[i1]; bus.req1_cin = v1_c[i1]; end
        else bus.req1_valid = 1'b0;
      end
      wait_valid("fair", cyc);
      check($sformatf("fair_res_t%0d", t), {bus.rsp_id, bus.rsp_cout, bus.rsp_sum},
            {gid[0], model});
      step();                     // pop edge
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;

    // Reset during beat 2 discards the in-flight result
    step();
    bus.req0_a = 64'h0123_4567_89AB_CDEF;
    bus.req0_b = 64'h1111_1111_1111_1111;
    bus.req0_cin = 1'b0;
    bus.req0_valid = 1'b1;
    #1;
    check("midrst_accept", bus.req0_ready, 1);
    step();                       // E0
    bus.req0_valid = 1'b0;
    step();                       // E1 (beat 0)
    step();                       // E2 (beat 1); beat 2 now in flight
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_sum", bus.rsp_sum, 0);
    step();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.rsp_valid) saw_valid = 1'b1;
    end
    check("midrst_no_rsp", saw_valid, 0);

    // Fresh request after release completes normally
    bus.req1_a = 64'h1234_5678_9ABC_DEF0;
    bus.req1_b = 64'h0FED_CBA9_8765_4321;
    bus.req1_cin = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check("post_rst_grant", bus.req1_ready, 1);
    step();
    bus.req1_valid = 1'b0;
    wait_valid("post_rst", cyc);
    check("post_rst_sum", bus.rsp_sum, 64'h2222_2222_2222_2212);
    check("post_rst_cout", bus.rsp_cout, 0);
    check("post_rst_id", bus.rsp_id, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_slice_scheduler.md
# adder_slice_scheduler

Sequencer and arbiter that shares one SLICE-bit adder slice between two requesters to perform full WIDTH-bit additions with carry-in. Each accepted request produces a WIDTH-bit sum and carry-out, matching `{c_out, sum} = a + b + c_in`. The slice is reused over WIDTH/SLICE beats, low slice first. The block sits in the arithmetic datapath wherever a full-width carry-select adder is too costly and multi-cycle latency is acceptable.

## Interface
- WIDTH, 64, operand and sum width; must be a multiple of SLICE.
- SLICE, 16, width of the shared adder slice; BEATS = WIDTH/SLICE (4 by default).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req0_valid  in  1  requester 0 has an operand set.
- req0_ready  out  1  requester 0 accepted this cycle; combinational.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid / req1_ready / req1_a / req1_b / req1_cin  same as requester 0, for requester 1.
- rsp_valid  out  1  a result is available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester index of the result.
- rsp_sum  out  WIDTH  sum, modulo 2^WIDTH.
- rsp_cout  out  1  carry-out of bit WIDTH-1.
- busy  out  1  high in the ADD and DONE states.

## Operation
- FSM states: IDLE, ADD, DONE.
- **IDLE**
  - If any reqN_valid is high, grant one requester and assert its reqN_ready only. A transfer occurs on that edge.
  - On transfer: capture a, b, cin, and the requester id. Set carry = cin and beat = 0. Go to ADD.
  - With no valid request, stay in IDLE.
- **ADD**
  - On each edge, compute {carry', s} = a[beat*SLICE +: SLICE] + b[beat*SLICE +: SLICE] + carry.
  - Write s into the accumulator at that slice position, update carry, and increment beat.
  - On the edge that processes beat BEATS-1, load the accumulator (with the final slice) into rsp_sum, load the final carry into rsp_cout, load the captured id into rsp_id, and go to DONE.
- **DONE**
  - rsp_valid = 1.
  - When rsp_ready is high, go to IDLE on that edge. No new request is accepted in that same cycle.
- **Arbitration**: round-robin with a one-bit last_grant pointer.
  - Only one valid: grant it, regardless of the pointer.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant updates only on a transfer.
- reqN_ready is 0 in ADD and DONE and while rst is high. Requesters must hold their valid signal and operands stable until ready.
- rsp_sum, rsp_cout and rsp_id change only on the final ADD beat. They hold their values after a pop until the next completion.
- Arithmetic is unsigned. Overflow appears only in rsp_cout; there are no other flags.

## Timing
- Reset values: state IDLE, last_grant = 1 (so req0 wins the first contention), rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, busy 0, reqN_ready 0.
- Latency: request accepted on edge E0, ADD beats on edges E1..E_BEATS, rsp_valid high in the cycle after E_BEATS.
  - With default parameters, rsp_valid rises 4 cycles after acceptance.
- Minimum initiation interval is BEATS+2 cycles: accept edge, BEATS add edges, then at least one DONE cycle with rsp_ready already high, then one IDLE cycle.
- Back-pressure: rsp_ready low holds DONE indefinitely. All rsp_* outputs are stable and no request is accepted.
- Simultaneous valid on both requesters in IDLE: exactly one ready is asserted, never both.
- Reset asserted mid-operation (ADD or DONE): return immediately to reset values. The in-flight result is discarded and no response is produced for it.
- A valid input deasserted in the same cycle its ready would have risen: no transfer, and last_grant is unchanged.

## Test plan
- **Reset**: hold rst high with both valids high → both readies 0, rsp_valid 0, rsp_sum 0, busy 0. After release, the first grant goes to req0.
- **Full carry ripple**: req0 a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → rsp_sum=0, rsp_cout=1, rsp_id=0, rsp_valid exactly 4 cycles after the accept edge.
- **Slice-boundary carry**: req1 a=64'h0000_0000_0000_FFFF, b=1, cin=0 → rsp_sum=64'h0000_0000_0001_0000, rsp_cout=0, rsp_id=1.
- **Fairness**: both requesters valid continuously and rsp_ready tied high → grants alternate 0,1,0,1 over 8 transactions. Every result equals the reference model a+b+cin.
- **Back-pressure**: rsp_ready low for 10 cycles in DONE → rsp_* stable and both readies 0 throughout. Raising rsp_ready pops the result; the next accept happens one cycle later.
- **Reset mid-op**: assert rst during beat 2 → rsp_valid never rises for that request. A request after release completes with the correct sum.
